// File: rtl/lsu_mmio.sv
// Load/store unit with a byte-addressed data memory and memory-mapped IO.
// The data memory is single-port and synchronous-read, with byte-lane write enables.
// Five writable IO output registers and a synchronised switch input share the upper map.
// Loads return one cycle after acceptance; erroneous accesses pulse o_err.
module lsu_mmio #(
    parameter int unsigned DMEM_WORDS = 2048,
    parameter int unsigned SW_SYNC    = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lsu_req,
    input  logic        i_lsu_wren,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_load_type,
    input  logic        i_load_signed,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    output logic        o_err,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_hex03,
    output logic [31:0] o_io_hex47,
    output logic [31:0] o_io_lcd
);

    localparam int unsigned AW         = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    // Address decode results
    logic        dmem_hit;
    logic        io_hit;
    logic        sw_hit;
    logic [2:0]  io_sel;

    // Access qualification
    logic        size_ok;
    logic        misalign;
    logic        acc_err;
    logic        st_ok;
    logic        ld_req;
    logic        dmem_we;
    logic        dmem_re;
    logic        io_we;

    // Lane-aligned store data and byte enables
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [AW-1:0] widx;

    // Storage
    logic [31:0] mem [DMEM_WORDS];
    logic [31:0] rdata;
    logic [31:0] io_reg [5];
    logic [31:0] sw_sync [SW_SYNC];
    logic [31:0] io_rd;

    // Load pipeline state captured at the accepting edge
    logic        ld_valid;
    logic        ld_err;
    logic        ld_from_dmem;
    logic [1:0]  ld_off;
    logic [3:0]  ld_type;
    logic        ld_signed;
    logic [31:0] io_rdata;
    logic [31:0] held;
    logic        err_q;

    // Load formatting
    logic [31:0] raw;
    logic [31:0] sh;
    logic [31:0] fmt;

    // Region decode: DMEM by byte bound, peripherals by 4 KiB page number
    always_comb begin
        io_hit   = 1'b0;
        sw_hit   = 1'b0;
        io_sel   = '0;
        dmem_hit = (i_lsu_addr < DMEM_BYTES);
        if (!dmem_hit) begin
            case (i_lsu_addr[31:12])
                20'h10000: begin io_hit = 1'b1; io_sel = 3'd0; end
                20'h10001: begin io_hit = 1'b1; io_sel = 3'd1; end
                20'h10002: begin io_hit = 1'b1; io_sel = 3'd2; end
                20'h10003: begin io_hit = 1'b1; io_sel = 3'd3; end
                20'h10004: begin io_hit = 1'b1; io_sel = 3'd4; end
                20'h10010: sw_hit = 1'b1;
                default:   ;
            endcase
        end
    end

    // Size legality and natural-alignment check
    always_comb begin
        size_ok  = 1'b1;
        misalign = 1'b0;
        case (i_load_type)
            4'h1:    ;
            4'h3:    misalign = i_lsu_addr[0];
            4'hF:    misalign = |i_lsu_addr[1:0];
            default: size_ok = 1'b0;
        endcase
    end

    assign acc_err = !size_ok || misalign || !(dmem_hit || io_hit || sw_hit)
                     || (i_lsu_wren && sw_hit);
    assign st_ok   = i_lsu_req && i_lsu_wren && !acc_err;
    assign ld_req  = i_lsu_req && !i_lsu_wren;
    assign dmem_we = st_ok && dmem_hit;
    assign io_we   = st_ok && io_hit;
    assign dmem_re = ld_req && !acc_err && dmem_hit;

    assign be    = i_load_type << i_lsu_addr[1:0];
    assign wdata = i_st_data << {i_lsu_addr[1:0], 3'b000};
    assign widx  = i_lsu_addr[AW+1:2];

    // Single-port data memory with byte-lane writes; contents are never reset
    always_ff @(posedge i_clk) begin
        if (dmem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (dmem_re) rdata <= mem[widx];
    end

    // IO output registers with byte-lane writes
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int unsigned r = 0; r < 5; r++) io_reg[r] <= '0;
        end else if (io_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) io_reg[io_sel][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign o_io_ledr  = io_reg[0];
    assign o_io_ledg  = io_reg[1];
    assign o_io_hex03 = io_reg[2];
    assign o_io_hex47 = io_reg[3];
    assign o_io_lcd   = io_reg[4];

    // Switch synchroniser chain
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int unsigned s = 0; s < SW_SYNC; s++) sw_sync[s] <= '0;
        end else begin
            sw_sync[0] <= i_io_sw;
            for (int unsigned s = 1; s < SW_SYNC; s++) sw_sync[s] <= sw_sync[s-1];
        end
    end

    assign io_rd = sw_hit ? sw_sync[SW_SYNC-1] : io_reg[io_sel];

    // Capture load context; the DMEM word arrives from the RAM output register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ld_valid     <= 1'b0;
            ld_err       <= 1'b0;
            ld_from_dmem <= 1'b0;
            ld_off       <= '0;
            ld_type      <= '0;
            ld_signed    <= 1'b0;
            io_rdata     <= '0;
            held         <= '0;
            err_q        <= 1'b0;
        end else begin
            ld_valid <= ld_req;
            err_q    <= i_lsu_req && acc_err;
            if (ld_req) begin
                ld_err       <= acc_err;
                ld_from_dmem <= dmem_hit;
                ld_off       <= i_lsu_addr[1:0];
                ld_type      <= i_load_type;
                ld_signed    <= i_load_signed;
                io_rdata     <= io_rd;
            end
            if (ld_valid) held <= fmt;
        end
    end

    // Lane extraction and extension after the RAM register, so latency stays one cycle
    always_comb begin
        raw = ld_from_dmem ? rdata : io_rdata;
        sh  = raw >> {ld_off, 3'b000};
        fmt = '0;
        case (ld_type)
            4'h1:    fmt = {{24{ld_signed & sh[7]}},  sh[7:0]};
            4'h3:    fmt = {{16{ld_signed & sh[15]}}, sh[15:0]};
            4'hF:    fmt = sh;
            default: fmt = '0;
        endcase
        if (ld_err) fmt = '0;
    end

    assign o_ld_valid = ld_valid;
    assign o_err      = err_q;
    assign o_ld_data  = ld_valid ? fmt : held;

endmodule

// File: tb/tb_lsu_mmio.sv
// Randomised self-checking bench for lsu_mmio against a byte-level memory-map model.
module tb_lsu_mmio;

    localparam int unsigned DW  = 2048;
    localparam int unsigned SWS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_lsu_req;
    logic        i_lsu_wren;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic [3:0]  i_load_type;
    logic        i_load_signed;
    logic [31:0] i_io_sw;
    logic [31:0] o_ld_data;
    logic        o_ld_valid;
    logic        o_err;
    logic [31:0] o_io_ledr, o_io_ledg, o_io_hex03, o_io_hex47, o_io_lcd;

    lsu_mmio #(.DMEM_WORDS(DW), .SW_SYNC(SWS)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_lsu_req    (i_lsu_req),
        .i_lsu_wren   (i_lsu_wren),
        .i_lsu_addr   (i_lsu_addr),
        .i_st_data    (i_st_data),
        .i_load_type  (i_load_type),
        .i_load_signed(i_load_signed),
        .i_io_sw      (i_io_sw),
        .o_ld_data    (o_ld_data),
        .o_ld_valid   (o_ld_valid),
        .o_err        (o_err),
        .o_io_ledr    (o_io_ledr),
        .o_io_ledg    (o_io_ledg),
        .o_io_hex03   (o_io_hex03),
        .o_io_hex47   (o_io_hex47),
        .o_io_lcd     (o_io_lcd)
    );

    always #5 clk = ~clk;

    // Reference state: byte-addressed memory, IO bytes, history of sampled switches
    logic [7:0]  dm [4*DW];
    logic [7:0]  io_b [5][4];
    logic [31:0] sw_hist [$];
    logic [31:0] exp_ld;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 0..4 IO register, 5 switches, 6 data memory, -1 unmapped
    function automatic int decode(input logic [31:0] a);
        if (a < 32'(4*DW)) return 6;
        case (a[31:12])
            20'h10000: return 0;
            20'h10001: return 1;
            20'h10002: return 2;
            20'h10003: return 3;
            20'h10004: return 4;
            20'h10010: return 5;
            default:   return -1;
        endcase
    endfunction

    function automatic int nbytes(input logic [3:0] t);
        case (t)
            4'h1:    return 1;
            4'h3:    return 2;
            4'hF:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] io_word(input int r);
        return {io_b[r][3], io_b[r][2], io_b[r][1], io_b[r][0]};
    endfunction

    task automatic check_io();
        check("ledr",  o_io_ledr,  io_word(0));
        check("ledg",  o_io_ledg,  io_word(1));
        check("hex03", o_io_hex03, io_word(2));
        check("hex47", o_io_hex47, io_word(3));
        check("lcd",   o_io_lcd,   io_word(4));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'b0, o_ld_valid}, 32'h0);
        check({tag, "_err"},   {31'b0, o_err},      32'h0);
        check({tag, "_data"},  o_ld_data,           32'h0);
        check({tag, "_ledr"},  o_io_ledr,           32'h0);
        check({tag, "_ledg"},  o_io_ledg,           32'h0);
        check({tag, "_hex03"}, o_io_hex03,          32'h0);
        check({tag, "_hex47"}, o_io_hex47,          32'h0);
        check({tag, "_lcd"},   o_io_lcd,            32'h0);
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge
    task automatic step(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] typ, input logic sgn);
        logic        exp_v, exp_e;
        logic [31:0] v, swv;
        logic [7:0]  b;
        int          r, n, o;
        i_lsu_req = req; i_lsu_wren = wr; i_lsu_addr = addr;
        i_st_data = data; i_load_type = typ; i_load_signed = sgn;
        @(posedge clk);
        swv = (sw_hist.size() >= SWS) ? sw_hist[sw_hist.size()-SWS] : 32'h0;
        sw_hist.push_back(i_io_sw);
        exp_v = req && !wr;
        exp_e = 1'b0;
        if (req) begin
            r = decode(addr);
            n = nbytes(typ);
            o = int'(addr[1:0]);
            if (n == 0 || r < 0) exp_e = 1'b1;
            else if ((addr % 32'(n)) != 0) exp_e = 1'b1;
            else if (wr && r == 5) exp_e = 1'b1;
            if (wr && !exp_e) begin
                for (int i = 0; i < n; i++) begin
                    b = data[8*i +: 8];
                    if (r == 6) dm[int'(addr) + i] = b;
                    else io_b[r][o + i] = b;
                end
            end
            if (exp_v) begin
                v = 32'h0;
                if (!exp_e) begin
                    for (int i = 0; i < n; i++) begin
                        if (r == 6)      b = dm[int'(addr) + i];
                        else if (r == 5) b = swv[8*(o + i) +: 8];
                        else             b = io_b[r][o + i];
                        v = v | (32'(b) << (8*i));
                    end
                    if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                end
                exp_ld = v;
            end
        end
        @(negedge clk);
        check("ld_valid", {31'b0, o_ld_valid}, {31'b0, exp_v});
        check("err",      {31'b0, o_err},      {31'b0, exp_e});
        check("ld_data",  o_ld_data,           exp_ld);
        check_io();
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr(input logic [3:0] typ);
        logic [31:0] a;
        int unsigned w;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: begin
                w = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : DW - 8 + $urandom_range(0, 7);
                a = 32'(w) * 32'd4 + 32'($urandom_range(0, 3));
            end
            5, 6: a = 32'h1000_0000 | (32'($urandom_range(0, 4)) << 12) | 32'($urandom_range(0, 4095));
            7:    a = 32'h1001_0000 | 32'($urandom_range(0, 4095));
            8: begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h2000_0000 | 32'($urandom_range(0, 4095));
                    1:       a = 32'(4*DW) + 32'($urandom_range(0, 255));
                    2:       a = 32'h1000_5000 | 32'($urandom_range(0, 4095));
                    default: a = 32'h1001_1000 | 32'($urandom_range(0, 4095));
                endcase
            end
            default: a = 32'(4*DW - 8) + 32'($urandom_range(0, 15));
        endcase
        if ($urandom_range(0, 3) != 0) begin
            if (typ == 4'h3) a[0] = 1'b0;
            else if (typ == 4'hF) a[1:0] = 2'b00;
        end
        return a;
    endfunction

    function automatic logic [3:0] rand_type();
        case ($urandom_range(0, 19))
            0, 1, 2, 3, 4, 5:        return 4'h1;
            6, 7, 8, 9, 10, 11:      return 4'h3;
            12, 13, 14, 15, 16:      return 4'hF;
            default:                 return 4'($urandom_range(0, 15));
        endcase
    endfunction

    // Reset asserted while a load is outstanding; nothing from it may surface
    task automatic reset_mid_load();
        i_lsu_req = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = 32'h0000_0010;
        i_load_type = 4'hF; i_load_signed = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        for (int r = 0; r < 5; r++) for (int k = 0; k < 4; k++) io_b[r][k] = 8'h00;
        exp_ld = 32'h0;
        sw_hist.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_hold_valid", {31'b0, o_ld_valid}, 32'h0);
            check("rst_hold_ledr",  o_io_ledr,           32'h0);
        end
        i_lsu_req = 1'b0;
        rst_n = 1'b1;
        idle(3);
    endtask

    initial begin
        logic [31:0] old_sw;
        logic [3:0]  t;
        rst_n = 1'b0;
        i_lsu_req = 1'b0; i_lsu_wren = 1'b0; i_lsu_addr = '0; i_st_data = '0;
        i_load_type = 4'hF; i_load_signed = 1'b0; i_io_sw = 32'hC0FF_EE00;
        for (int r = 0; r < 5; r++) for (int k = 0; k < 4; k++) io_b[r][k] = 8'h00;
        exp_ld = 32'h0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Populate the DMEM window used by random loads
        for (int w = 0; w < 32; w++) step(1'b1, 1'b1, 32'(w*4), $urandom, 4'hF, 1'b0);
        for (int w = DW - 8; w < DW; w++) step(1'b1, 1'b1, 32'(w*4), $urandom, 4'hF, 1'b0);

        // LCD word store anywhere in its page
        step(1'b1, 1'b1, 32'h1000_40FC, 32'h3333_3333, 4'hF, 1'b0);
        check("lcd_store", o_io_lcd, 32'h3333_3333);
        check("lcd_err", {31'b0, o_err}, 32'h0);

        // Half load extension directly after the store
        step(1'b1, 1'b1, 32'h0000_0010, 32'h0000_FF75, 4'hF, 1'b0);
        step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h3, 1'b1);
        check("half_s_valid", {31'b0, o_ld_valid}, 32'h1);
        check("half_s_data", o_ld_data, 32'hFFFF_FF75);
        step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h3, 1'b0);
        check("half_u_data", o_ld_data, 32'h0000_FF75);

        // Byte lane write into LEDR and signed byte readback
        step(1'b1, 1'b1, 32'h1000_0000, 32'h1111_1111, 4'hF, 1'b0);
        step(1'b1, 1'b1, 32'h1000_0003, 32'h0000_00AB, 4'h1, 1'b0);
        check("ledr_byte", o_io_ledr, 32'hAB11_1111);
        step(1'b1, 1'b0, 32'h1000_0003, 32'h0, 4'h1, 1'b1);
        check("ledr_byte_ld", o_ld_data, 32'hFFFF_FFAB);

        // Misaligned store and unmapped load
        step(1'b1, 1'b1, 32'h0000_0012, 32'hDEAD_BEEF, 4'hF, 1'b0);
        check("misalign_err", {31'b0, o_err}, 32'h1);
        step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0);
        check("misalign_nowrite", o_ld_data, 32'h0000_FF75);
        step(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'hF, 1'b0);
        check("unmapped_err", {31'b0, o_err}, 32'h1);
        check("unmapped_data", o_ld_data, 32'h0);

        // DMEM upper bound
        step(1'b1, 1'b0, 32'(4*DW - 4), 32'h0, 4'hF, 1'b0);
        step(1'b1, 1'b0, 32'(4*DW), 32'h0, 4'hF, 1'b0);
        check("dmem_bound_err", {31'b0, o_err}, 32'h1);

        // Switch synchroniser latency and read-only enforcement
        old_sw = 32'h5A5A_0F0F;
        i_io_sw = old_sw;
        idle(SWS + 1);
        i_io_sw = 32'h6666_6666;
        for (int k = 0; k < SWS + 2; k++) begin
            step(1'b1, 1'b0, 32'h1001_0000, 32'h0, 4'hF, 1'b0);
            check("sw_latency", o_ld_data, (k < SWS) ? old_sw : 32'h6666_6666);
        end
        step(1'b1, 1'b1, 32'h1001_0000, 32'h1234_5678, 4'hF, 1'b0);
        check("sw_store_err", {31'b0, o_err}, 32'h1);

        // Reset during an outstanding load; DMEM must survive
        reset_mid_load();
        step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0);
        check("dmem_kept", o_ld_data, 32'h0000_FF75);

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 9) == 0) i_io_sw = $urandom;
            t = rand_type();
            step(($urandom_range(0, 4) != 0), ($urandom_range(0, 1) == 1), rand_addr(t),
                 $urandom, t, ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
